// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin share of one ALU between two requesters, with a result timeout
module alu_req_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [3:0]       req0_fun_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [3:0]       req1_fun_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [3:0]       alu_fun_o,
  output logic             alu_en_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_out_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic             busy_o
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             last_q;
  logic             id_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [3:0]       alu_fun_q;
  logic             alu_en_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             win;
  logic             any_req;
  // win selects requester 1; on a tie the one that did not win last time goes
  assign win          = req1_valid_i & (~req0_valid_i | ~last_q);
  assign any_req      = req0_valid_i | req1_valid_i;
  assign req0_ready_o = rst_ni && state_q == IDLE && req0_valid_i && !win;
  assign req1_ready_o = rst_ni && state_q == IDLE && win;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_fun_o    = alu_fun_q;
  assign alu_en_o     = alu_en_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      alu_en_q <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          id_q      <= win;
          alu_a_q   <= win ? req1_a_i : req0_a_i;
          alu_b_q   <= win ? req1_b_i : req0_b_i;
          alu_fun_q <= win ? req1_fun_i : req0_fun_i;
          alu_en_q  <= 1'b1;
          busy_q    <= 1'b1;
          state_q   <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        // a result arriving on the last allowed cycle still beats the timeout
        WAIT: if (alu_out_valid_i) begin
          rsp_data_q  <= alu_out_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_q  <= '0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          last_q      <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scenario tasks plus a response scoreboard for alu_req_arbiter
module tb_alu_req_arbiter;
  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_fun, req1_fun;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_fun;
  logic        alu_en, alu_out_valid;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;
  logic        exp_last;
  logic [17:0] sb[$];
  logic [17:0] e;
  int          total = 0;
  int          bad = 0;

  alu_req_arbiter #(.WIDTH(16), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_fun_i(req0_fun),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_fun_i(req1_fun),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_o(alu_fun), .alu_en_o(alu_en),
    .alu_out_i(alu_out), .alu_out_valid_i(alu_out_valid),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    return a + b + {12'h000, f};
  endfunction

  // scoreboard: every response handshake pops one expectation {id, data, err}
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got id=%0d data=%h err=%b, required no response", rsp_id, rsp_data, rsp_err);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_data, rsp_err} !== e) begin
          bad++;
          $display("FAIL sb_rsp got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                   rsp_id, rsp_data, rsp_err, e[17], e[16:1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #11;
    total++;
    if ({alu_a, alu_b, alu_fun, alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got a=%h b=%h fun=%h en=%b rv=%b id=%b d=%h err=%b busy=%b r0=%b r1=%b, required all 0",
               alu_a, alu_b, alu_fun, alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL reset_first_tie got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    exp_last = 1'b1;
    step;
  endtask

  task automatic test_single;
    req0_a = 16'h0005; req0_b = 16'h0003; req0_fun = 4'b0000; req0_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL single_ready got r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, 16'h0008, 1'b0});
    step;
    total++;
    if ({alu_en, busy, req0_ready, alu_a, alu_b, alu_fun} !== {3'b110, 16'h0005, 16'h0003, 4'h0}) begin
      bad++;
      $display("FAIL single_issue got en=%b busy=%b r0=%b a=%h b=%h fun=%h, required en=1 busy=1 r0=0 a=0005 b=0003 fun=0",
               alu_en, busy, req0_ready, alu_a, alu_b, alu_fun);
    end
    req0_valid = 1'b0;
    step;
    total++;
    if ({alu_en, rsp_valid} !== 2'b00) begin
      bad++;
      $display("FAIL single_wait got en=%b rv=%b, required 0 0", alu_en, rsp_valid);
    end
    alu_out = alu_f(alu_a, alu_b, alu_fun); alu_out_valid = 1'b1;
    step;
    alu_out_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== {1'b1, 1'b0, 16'h0008, 1'b0}) begin
      bad++;
      $display("FAIL single_rsp got rv=%b id=%b d=%h err=%b, required rv=1 id=0 d=0008 err=0", rsp_valid, rsp_id, rsp_data, rsp_err);
    end
    rsp_ready = 1'b1;
    step;
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL single_done got rv=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
    exp_last = 1'b0;
  endtask

  task automatic test_fairness;
    logic        g;
    logic [15:0] pa, pb;
    logic [3:0]  pf;
    req0_a = 16'h1000; req0_b = 16'h0011; req0_fun = 4'h2;
    req1_a = 16'h2000; req1_b = 16'h0022; req1_fun = 4'h7;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      g = ~exp_last;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== (g ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL fair_ready op=%0d got r0=%b r1=%b, required winner %0d", op, req0_ready, req1_ready, g);
      end
      pa = g ? req1_a : req0_a; pb = g ? req1_b : req0_b; pf = g ? req1_fun : req0_fun;
      sb.push_back({g, alu_f(pa, pb, pf), 1'b0});
      step;
      total++;
      if ({alu_en, alu_a} !== {1'b1, pa}) begin
        bad++;
        $display("FAIL fair_issue op=%0d got en=%b a=%h, required en=1 a=%h", op, alu_en, alu_a, pa);
      end
      if (g) req1_a = req1_a + 16'h0101; else req0_a = req0_a + 16'h0101;
      step;
      alu_out = alu_f(alu_a, alu_b, alu_fun); alu_out_valid = 1'b1;
      step;
      alu_out_valid = 1'b0;
      total++;
      if ({rsp_valid, rsp_id} !== {1'b1, g}) begin
        bad++;
        $display("FAIL fair_rsp op=%0d got rv=%b id=%b, required rv=1 id=%b", op, rsp_valid, rsp_id, g);
      end
      exp_last = g;
      step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int n;
    req1_a = 16'h0abc; req1_b = 16'h0001; req1_fun = 4'hf; req1_valid = 1'b1; rsp_ready = 1'b1;
    sb.push_back({1'b1, 16'h0000, 1'b1});
    step;
    total++;
    if (alu_en !== 1'b1) begin
      bad++;
      $display("FAIL to_issue got en=%b, required 1", alu_en);
    end
    req1_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    total++;
    if (n != 9) begin
      bad++;
      $display("FAIL to_latency got %0d cycles after en, required 9", n);
    end
    total++;
    if ({rsp_id, rsp_data, rsp_err} !== {1'b1, 16'h0000, 1'b1}) begin
      bad++;
      $display("FAIL to_rsp got id=%b d=%h err=%b, required id=1 d=0000 err=1", rsp_id, rsp_data, rsp_err);
    end
    exp_last = 1'b1;
    step;
    alu_out = 16'h1234; alu_out_valid = 1'b1;
    step;
    step;
    alu_out_valid = 1'b0;
    total++;
    if ({rsp_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL to_late got rv=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [15:0] f0, f1;
    req0_a = 16'h0100; req0_b = 16'h0200; req0_fun = 4'h3; req0_valid = 1'b1; rsp_ready = 1'b0;
    f0 = alu_f(req0_a, req0_b, req0_fun);
    sb.push_back({1'b0, f0, 1'b0});
    step;
    req0_valid = 1'b0;
    step;
    alu_out = alu_f(alu_a, alu_b, alu_fun); alu_out_valid = 1'b1;
    step;
    alu_out_valid = 1'b0;
    req1_a = 16'h7000; req1_b = 16'h0001; req1_fun = 4'h1; req1_valid = 1'b1;
    f1 = alu_f(req1_a, req1_b, req1_fun);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_id, rsp_data, rsp_err, req1_ready, busy} !== {1'b1, 1'b0, f0, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got rv=%b id=%b d=%h err=%b r1=%b busy=%b, required rv=1 id=0 d=%h err=0 r1=0 busy=1",
                 i, rsp_valid, rsp_id, rsp_data, rsp_err, req1_ready, busy, f0);
      end
      step;
    end
    rsp_ready = 1'b1;
    step;
    total++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got rv=%b r1=%b, required rv=0 r1=1", rsp_valid, req1_ready);
    end
    sb.push_back({1'b1, f1, 1'b0});
    step;
    total++;
    if ({alu_en, alu_a} !== {1'b1, 16'h7000}) begin
      bad++;
      $display("FAIL bp_issue got en=%b a=%h, required en=1 a=7000", alu_en, alu_a);
    end
    req1_valid = 1'b0;
    step;
    alu_out = alu_f(alu_a, alu_b, alu_fun); alu_out_valid = 1'b1;
    step;
    alu_out_valid = 1'b0;
    exp_last = 1'b1;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    req0_a = 16'h1111; req0_b = 16'h0002; req0_fun = 4'h5; req0_valid = 1'b1; rsp_ready = 1'b1;
    sb.push_back({1'b0, 16'hbeef, 1'b0});
    step;
    req0_valid = 1'b0;
    for (int i = 0; i < 8; i++) step;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL simul_early got rv=%b, required 0", rsp_valid);
    end
    alu_out = 16'hbeef; alu_out_valid = 1'b1;
    step;
    alu_out_valid = 1'b0;
    total++;
    if ({rsp_valid, rsp_data, rsp_err} !== {1'b1, 16'hbeef, 1'b0}) begin
      bad++;
      $display("FAIL simul_rsp got rv=%b d=%h err=%b, required rv=1 d=beef err=0", rsp_valid, rsp_data, rsp_err);
    end
    exp_last = 1'b0;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    req1_a = 16'h4444; req1_b = 16'h0004; req1_fun = 4'h4; req1_valid = 1'b1; rsp_ready = 1'b1;
    step;
    req1_valid = 1'b0;
    step;
    step;
    req0_a = 16'h0aaa; req0_b = 16'h0001; req0_fun = 4'h0;
    req1_a = 16'h0bbb; req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({alu_a, alu_b, alu_fun, alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready} !== '0) begin
      bad++;
      $display("FAIL rst_wait_outputs got a=%h b=%h fun=%h en=%b rv=%b id=%b d=%h err=%b busy=%b r0=%b r1=%b, required all 0",
               alu_a, alu_b, alu_fun, alu_en, rsp_valid, rsp_id, rsp_data, rsp_err, busy, req0_ready, req1_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL rst_wait_tie got r0=%b r1=%b, required r0=1 r1=0", req0_ready, req1_ready);
    end
    sb.push_back({1'b0, alu_f(16'h0aaa, 16'h0001, 4'h0), 1'b0});
    step;
    total++;
    if ({alu_en, alu_a} !== {1'b1, 16'h0aaa}) begin
      bad++;
      $display("FAIL rst_wait_issue got en=%b a=%h, required en=1 a=0aaa", alu_en, alu_a);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step;
    alu_out = alu_f(alu_a, alu_b, alu_fun); alu_out_valid = 1'b1;
    step;
    alu_out_valid = 1'b0;
    step;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; rsp_ready = 1'b0; alu_out = '0; alu_out_valid = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_fun = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0;
    exp_last = 1'b1;
    test_reset;
    test_single;
    test_fairness;
    test_timeout;
    test_backpressure;
    test_simultaneous;
    test_reset_mid_wait;
    step;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got %0d pending responses, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
